stage_sequencer: RTL

//  Multi-cycle control FSM that drives stage[2:0] into main_memory_control.

---
 rtl/stage_sequencer.sv | 111 +++++++++++
 1 files changed

// File: rtl/stage_sequencer.sv
// Multi-cycle control sequencer: FETCH -> MEM_READ -> REG_UPDATE -> MEM_WRITE -> PC_UPDATE, owning PC and latched instruction/read data.
// Latency: 5 cycles/instruction minimum (3 with STAGE_SKIP_EN defined); all outputs registered.
// Backpressure: read stages stall indefinitely until mem_ready; HALTED is left only via rst.
module stage_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_read_data,
  input  logic        mem_ready,
  input  logic        needs_mem_read,
  input  logic        needs_mem_write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        halt_req,
  output logic [2:0]  stage,
  output logic [31:0] PC_value,
  output logic [31:0] instruction,
  output logic [31:0] read_data,
  output logic        halted,
  output logic [31:0] retired_count
);

  typedef enum logic [2:0] {
    FETCH      = 3'd0,
    MEM_READ   = 3'd1,
    REG_UPDATE = 3'd2,
    MEM_WRITE  = 3'd3,
    PC_UPDATE  = 3'd4,
    HALTED     = 3'd5
  } stage_e;

  stage_e      state_q, state_d;
  logic [31:0] pc_d, instr_d, rdata_d, retired_d;

`ifndef STAGE_SKIP_EN
  logic unused_needs;
  assign unused_needs = needs_mem_read ^ needs_mem_write;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FETCH;
      PC_value      <= RESET_PC;
      instruction   <= 32'h0;
      read_data     <= 32'h0;
      retired_count <= 32'h0;
      halted        <= 1'b0;
    end else begin
      state_q       <= state_d;
      PC_value      <= pc_d;
      instruction   <= instr_d;
      read_data     <= rdata_d;
      retired_count <= retired_d;
      halted        <= (state_d == HALTED);
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = PC_value;
    instr_d   = instruction;
    rdata_d   = read_data;
    retired_d = retired_count;
    case (state_q)
      FETCH: begin
        if (mem_ready) begin
          instr_d = mem_read_data;
`ifdef STAGE_SKIP_EN
          state_d = needs_mem_read ? MEM_READ : REG_UPDATE;
`else
          state_d = MEM_READ;
`endif
        end
      end
      MEM_READ: begin
        if (mem_ready) begin
          rdata_d = mem_read_data;
          state_d = REG_UPDATE;
        end
      end
      REG_UPDATE: begin
`ifdef STAGE_SKIP_EN
        state_d = needs_mem_write ? MEM_WRITE : PC_UPDATE;
`else
        state_d = MEM_WRITE;
`endif
      end
      MEM_WRITE: state_d = PC_UPDATE;
      PC_UPDATE: begin
        retired_d = retired_count + 32'd1;
        // halt outranks a simultaneous branch; PC is frozen at the halting instruction
        if (halt_req) begin
          state_d = HALTED;
        end else if (branch_taken) begin
          pc_d    = branch_target;
          state_d = FETCH;
        end else begin
          pc_d    = PC_value + PC_STEP;
          state_d = FETCH;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = FETCH;
    endcase
  end

  assign stage = state_q;

endmodule
